fir_mac_sequencer: RTL and testbench
====================================

// Module: fir_mac_sequencer
// PURPOSE
// - Serial FIR controller: time-shares one signed multiply-accumulate across N_TAPS taps.
// - Owns the sample delay line and the coefficient register file, sequences the MAC per sample, and emits one filtered output per input.
// - Sits between the io_in sample pins and the io_out pins, in place of a fully parallel tap datapath.
// PARAMETERS
// - N_TAPS   4  number of taps / coefficients (>=2)
// - BW_in    2  signed input sample width
// - BW_coef  2  signed coefficient width
// - BW_acc   6  signed accumulator width; must hold N_TAPS*max|x*c| without overflow
// - BW_out   3  signed output width
// PORTS
// - clk        in   1                  clock
// - reset      in   1                  asynchronous, active-high reset
// - x_in       in   BW_in              signed input sample
// - x_valid    in   1                  x_in valid
// - x_ready    out  1                  block can accept a sample (combinational: state==IDLE)
// - coef_wr    in   1                  coefficient write strobe
// - coef_addr  in   $clog2(N_TAPS)     tap index for the write
// - coef_data  in   BW_coef            signed coefficient value
// - y_out      out  BW_out             signed filtered output (registered)
// - y_valid    out  1                  one-cycle pulse, y_out updated
// - busy       out  1                  state==MAC
// BEHAVIOUR
// - Single clock domain: clk. Reset is asynchronous, active-high.
// - Reset clears delay line d[0..N-1], coef[0..N-1], acc, idx, y_out to 0; y_valid=0; state=IDLE, so x_ready=1 while in reset.
// - FSM, two states:
//   - IDLE: x_ready=1. On x_valid at edge E0:
//     - shift: d[0]<=x_in, d[k]<=d[k-1];
//     - acc<=0, idx<=0; ->MAC.
//   - MAC: x_ready=0, busy=1. Each edge: acc<=acc+coef[idx]*d[idx] (full-precision signed product, sign-extended to BW_acc), idx<=idx+1.
//   - On the edge where idx==N_TAPS-1 (edge E_N):
//     - y_out<=fmt(acc+coef[idx]*d[idx]);
//     - y_valid<=1; ->IDLE.
// - Timing:
//   - y_valid high the cycle after E_N, i.e. N_TAPS edges after accept; deasserts next edge unless re-set.
//   - Next sample is accepted at E_(N+1) at the earliest. Throughput 1 sample / (N_TAPS+1) cycles.
// - Handshake:
//   - x_valid with x_ready=0 is not consumed; the sender holds x_in.
//   - No sample is lost or duplicated.
// - Coefficient writes:
//   - Take effect on the edge in IDLE only; ignored in MAC (no mid-sample coefficient change).
//   - coef_addr>=N_TAPS is ignored.
//   - A write and a sample accept on the same IDLE edge: the write lands; the MAC for that sample uses the new value.
// - fmt() default: two's-complement wrap, y_out=acc[BW_out-1:0].
// - reset mid-MAC: sequence aborted, no y_valid, delay line zeroed.
// - y_out holds its last value until the next completed sample.
// CONFIGURATION
// - Macro FIR_MAC_SAT_EN:
//   - Defined: fmt() clamps to [-2^(BW_out-1), 2^(BW_out-1)-1] (e.g. -4..3 for BW_out=3) when acc is out of range; otherwise as wrap.
//   - Undefined: pure wrap as above; no comparator logic synthesized.
// TESTING (defaults)
// - T1 reset:
//   - reset high 2 cycles mid-MAC -> y_valid=0, y_out=0, x_ready=1, busy=0 immediately (async);
//   - release -> no spurious y_valid.
// - T2 impulse:
//   - coefs {1,-1,1,-2}; samples 1,0,0,0;
//   - -> y_out 1,-1,1,-2, each y_valid exactly 4 edges after its accept.
// - T3 backpressure:
//   - x_valid held high continuously with values 1,1,1,1;
//   - -> accepts spaced 5 cycles, 4 y_valid pulses, y_out 1,0,1,-1 (coefs of T2).
// - T4 write lockout:
//   - coef_wr addr0=-2 during MAC -> ignored, current and next output unchanged;
//   - same write in IDLE -> next impulse gives y_out=-2.
// - T5 overflow:
//   - coefs all -2, samples -2 x4 -> 4th acc=16;
//   - y_out=0 without FIR_MAC_SAT_EN, y_out=3 with it.
// - T6 bad addr: coef_wr addr>=N_TAPS (N_TAPS=3 build) -> no coefficient changes.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// Serial FIR: one signed MAC time-shared across N_TAPS taps per sample.
// Define FIR_MAC_SAT_EN to saturate y_out instead of wrapping it.
module fir_mac_sequencer #(
  parameter int N_TAPS  = 4,
  parameter int BW_in   = 2,
  parameter int BW_coef = 2,
  parameter int BW_acc  = 6,
  parameter int BW_out  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [BW_in-1:0]   x_in,
  input  logic                      x_valid,
  output logic                      x_ready,
  input  logic                      coef_wr,
  input  logic [$clog2(N_TAPS)-1:0] coef_addr,
  input  logic signed [BW_coef-1:0] coef_data,
  output logic signed [BW_out-1:0]  y_out,
  output logic                      y_valid,
  output logic                      busy
);

  localparam int AW = $clog2(N_TAPS);
  localparam int PW = BW_in + BW_coef;

  typedef enum logic {
    IDLE,
    MAC
  } state_t;

  state_t state, state_nx;

  logic signed [BW_in-1:0]   d    [N_TAPS];
  logic signed [BW_coef-1:0] coef [N_TAPS];
  logic signed [BW_acc-1:0]  acc;
  logic signed [BW_acc-1:0]  acc_sum;
  logic signed [BW_acc-1:0]  prod_ext;
  logic signed [PW-1:0]      prod;
  logic signed [BW_out-1:0]  y_fmt;
  logic [AW-1:0]             idx;
  logic                      accept;
  logic                      last;
  logic                      coef_we;

  assign x_ready  = (state == IDLE);
  assign busy     = (state == MAC);
  assign accept   = x_ready && x_valid;
  assign last     = (idx == AW'(N_TAPS - 1));
  assign coef_we  = coef_wr && x_ready
                  && (int'(coef_addr) < N_TAPS);
  assign prod     = coef[idx] * d[idx];
  assign prod_ext = BW_acc'(prod);
  assign acc_sum  = acc + prod_ext;

`ifdef FIR_MAC_SAT_EN
  localparam logic signed [BW_acc-1:0] Y_MAX =
    BW_acc'((1 << (BW_out - 1)) - 1);
  localparam logic signed [BW_acc-1:0] Y_MIN = ~Y_MAX;

  always_comb begin
    y_fmt = acc_sum[BW_out-1:0];
    if (acc_sum > Y_MAX)
      y_fmt = Y_MAX[BW_out-1:0];
    else if (acc_sum < Y_MIN)
      y_fmt = Y_MIN[BW_out-1:0];
  end
`else
  assign y_fmt = acc_sum[BW_out-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = MAC;
      MAC:  if (last)   state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_TAPS; k++) begin
        d[k]    <= '0;
        coef[k] <= '0;
      end
      acc     <= '0;
      idx     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      for (int k = 0; k < N_TAPS; k++)
        if (coef_we && coef_addr == AW'(k))
          coef[k] <= coef_data;
      unique case (state)
        IDLE: begin
          if (accept) begin
            d[0] <= x_in;
            for (int k = 1; k < N_TAPS; k++)
              d[k] <= d[k-1];
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          idx <= idx + 1'b1;
          if (last) begin
            idx     <= '0;
            y_out   <= y_fmt;
            y_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer (4-tap and 3-tap builds).
// Expected outputs are hand-computed tap sums.
module tb_fir_mac_sequencer;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic signed [1:0] x_in = '0;
  logic              x_valid = 1'b0;
  logic              x_ready;
  logic              coef_wr = 1'b0;
  logic [1:0]        coef_addr = '0;
  logic signed [1:0] coef_data = '0;
  logic signed [2:0] y_out;
  logic              y_valid;
  logic              busy;

  logic signed [1:0] x_in3 = '0;
  logic              x_valid3 = 1'b0;
  logic              x_ready3;
  logic              coef_wr3 = 1'b0;
  logic [1:0]        coef_addr3 = '0;
  logic signed [1:0] coef_data3 = '0;
  logic signed [2:0] y_out3;
  logic              y_valid3;
  logic              busy3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer dut (
    .clk(clk), .reset(reset),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .coef_wr(coef_wr), .coef_addr(coef_addr),
    .coef_data(coef_data),
    .y_out(y_out), .y_valid(y_valid), .busy(busy)
  );

  fir_mac_sequencer #(.N_TAPS(3)) dut3 (
    .clk(clk), .reset(reset),
    .x_in(x_in3), .x_valid(x_valid3), .x_ready(x_ready3),
    .coef_wr(coef_wr3), .coef_addr(coef_addr3),
    .coef_data(coef_data3),
    .y_out(y_out3), .y_valid(y_valid3), .busy(busy3)
  );

  task automatic write_coef(input logic [1:0] a,
                            input logic signed [1:0] v);
    coef_wr = 1'b1; coef_addr = a; coef_data = v;
    @(posedge clk); #1;
    coef_wr = 1'b0;
  endtask

  task automatic set_coefs(input logic signed [1:0] c0,
                           input logic signed [1:0] c1,
                           input logic signed [1:0] c2,
                           input logic signed [1:0] c3);
    write_coef(2'd0, c0);
    write_coef(2'd1, c1);
    write_coef(2'd2, c2);
    write_coef(2'd3, c3);
  endtask

  // wr_mode: 0 none, 1 write on the accept edge, 2 write mid-MAC
  task automatic send(input logic signed [1:0] x,
                      input int wr_mode,
                      input logic [1:0] a,
                      input logic signed [1:0] v,
                      output logic signed [2:0] y,
                      output int lat);
    int guard;
    guard = 0;
    lat = -1;
    y = 'x;
    while (!x_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    x_in = x; x_valid = 1'b1;
    if (wr_mode == 1) begin
      coef_wr = 1'b1; coef_addr = a; coef_data = v;
    end
    @(posedge clk); #1;
    x_valid = 1'b0; coef_wr = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (wr_mode == 2 && c == 2) begin
        coef_wr = 1'b1; coef_addr = a; coef_data = v;
      end
      @(posedge clk); #1;
      coef_wr = 1'b0;
      if (y_valid) begin
        lat = c;
        y = y_out;
        break;
      end
    end
  endtask

  task automatic send3(input logic signed [1:0] x,
                       output logic signed [2:0] y,
                       output int lat);
    lat = -1;
    y = 'x;
    x_in3 = x; x_valid3 = 1'b1;
    @(posedge clk); #1;
    x_valid3 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (y_valid3) begin
        lat = c;
        y = y_out3;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if (x_ready !== 1'b1 || busy !== 1'b0 ||
        y_valid !== 1'b0 || y_out !== 3'sd0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b busy=%b vld=%b y=%0d want 1 0 0 0",
               x_ready, busy, y_valid, y_out);
    end
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_impulse;
    logic signed [2:0] exp_y [4];
    logic signed [1:0] xs [4];
    logic signed [2:0] y;
    int lat;
    exp_y = '{3'sd1, -3'sd1, 3'sd1, -3'sd2};
    xs = '{2'sd1, 2'sd0, 2'sd0, 2'sd0};
    set_coefs(2'sd1, -2'sd1, 2'sd1, -2'sd2);
    for (int i = 0; i < 4; i++) begin
      send(xs[i], 0, 2'd0, 2'sd0, y, lat);
      n_cmp++;
      if (y !== exp_y[i]) begin
        n_err++;
        $display("FAIL impulse_y[%0d]: got %0d want %0d", i, y, exp_y[i]);
      end
      n_cmp++;
      if (lat !== 4) begin
        n_err++;
        $display("FAIL impulse_lat[%0d]: got %0d want 4", i, lat);
      end
      if (i == 0) begin
        @(posedge clk); #1;
        n_cmp++;
        if (y_valid !== 1'b0) begin
          n_err++;
          $display("FAIL impulse_pulse: y_valid=%b want 0", y_valid);
        end
      end
    end
  endtask

  task automatic test_reset_mid_mac;
    int pulses;
    logic signed [2:0] y;
    int lat;
    x_in = 2'sd1; x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (y_valid !== 1'b0 || y_out !== 3'sd0 ||
        x_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: vld=%b y=%0d rdy=%b busy=%b want 0 0 1 0",
               y_valid, y_out, x_ready, busy);
    end
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (y_valid) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL reset_spurious: pulses=%0d want 0", pulses);
    end
    set_coefs(2'sd1, -2'sd1, 2'sd1, -2'sd2);
    send(2'sd0, 0, 2'd0, 2'sd0, y, lat);
    n_cmp++;
    if (y !== 3'sd0) begin
      n_err++;
      $display("FAIL reset_dline: got %0d want 0", y);
    end
  endtask

  task automatic test_backpressure;
    int acc_c [4];
    int y_c [4];
    logic signed [2:0] y_v [4];
    logic signed [2:0] exp_y [4];
    int na, ny;
    logic pre;
    exp_y = '{3'sd1, 3'sd0, 3'sd1, -3'sd1};
    na = 0; ny = 0;
    x_in = 2'sd1; x_valid = 1'b1;
    pre = x_ready;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (pre && x_valid && na < 4) begin
        acc_c[na] = c;
        na++;
        if (na == 4) x_valid = 1'b0;
      end
      if (y_valid && ny < 4) begin
        y_c[ny] = c;
        y_v[ny] = y_out;
        ny++;
      end else if (y_valid) ny++;
      pre = x_ready;
    end
    x_valid = 1'b0;
    n_cmp++;
    if (na !== 4 || ny !== 4) begin
      n_err++;
      $display("FAIL bp_count: accepts=%0d pulses=%0d want 4 4", na, ny);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (y_v[i] !== exp_y[i]) begin
          n_err++;
          $display("FAIL bp_y[%0d]: got %0d want %0d", i, y_v[i], exp_y[i]);
        end
        n_cmp++;
        if (y_c[i] - acc_c[i] !== 4) begin
          n_err++;
          $display("FAIL bp_lat[%0d]: got %0d want 4", i, y_c[i] - acc_c[i]);
        end
        if (i > 0) begin
          n_cmp++;
          if (acc_c[i] - acc_c[i-1] !== 5) begin
            n_err++;
            $display("FAIL bp_space[%0d]: got %0d want 5",
                     i, acc_c[i] - acc_c[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_write_lockout;
    logic signed [2:0] y;
    int lat;
    for (int i = 0; i < 4; i++) send(2'sd0, 0, 2'd0, 2'sd0, y, lat);
    send(2'sd1, 2, 2'd0, -2'sd2, y, lat);
    n_cmp++;
    if (y !== 3'sd1) begin
      n_err++;
      $display("FAIL lock_cur: got %0d want 1", y);
    end
    send(2'sd1, 0, 2'd0, 2'sd0, y, lat);
    n_cmp++;
    if (y !== 3'sd0) begin
      n_err++;
      $display("FAIL lock_next: got %0d want 0", y);
    end
    for (int i = 0; i < 4; i++) send(2'sd0, 0, 2'd0, 2'sd0, y, lat);
    send(2'sd1, 1, 2'd0, -2'sd2, y, lat);
    n_cmp++;
    if (y !== -3'sd2) begin
      n_err++;
      $display("FAIL idle_write: got %0d want -2", y);
    end
  endtask

  task automatic test_overflow;
    logic signed [2:0] exp_y [4];
    logic signed [2:0] y;
    int lat;
`ifdef FIR_MAC_SAT_EN
    exp_y = '{3'sd3, 3'sd3, 3'sd3, 3'sd3};
`else
    exp_y = '{-3'sd4, 3'sd0, -3'sd4, 3'sd0};
`endif
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    set_coefs(-2'sd2, -2'sd2, -2'sd2, -2'sd2);
    for (int i = 0; i < 4; i++) begin
      send(-2'sd2, 0, 2'd0, 2'sd0, y, lat);
      n_cmp++;
      if (y !== exp_y[i]) begin
        n_err++;
        $display("FAIL overflow_y[%0d]: got %0d want %0d", i, y, exp_y[i]);
      end
    end
  endtask

  task automatic test_bad_addr;
    logic signed [2:0] exp_y [3];
    logic signed [1:0] cv [4];
    logic signed [1:0] xs [3];
    logic signed [2:0] y;
    int lat;
    exp_y = '{3'sd1, -3'sd1, 3'sd1};
    cv = '{2'sd1, -2'sd1, 2'sd1, -2'sd2};
    xs = '{2'sd1, 2'sd0, 2'sd0};
    for (int i = 0; i < 4; i++) begin
      coef_wr3 = 1'b1; coef_addr3 = 2'(i); coef_data3 = cv[i];
      @(posedge clk); #1;
      coef_wr3 = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      send3(xs[i], y, lat);
      n_cmp++;
      if (y !== exp_y[i] || lat !== 3) begin
        n_err++;
        $display("FAIL bad_addr[%0d]: y=%0d lat=%0d want %0d 3",
                 i, y, lat, exp_y[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_impulse;
    test_reset_mid_mac;
    test_backpressure;
    test_write_lockout;
    test_overflow;
    test_bad_addr;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
